activation_lut_requester: RTL and testbench

//  Requesting side of the activation ROM interface. Takes a valid/ready stream of signed neuron sums.

---
 rtl/activation_lut_requester.sv | 134 +++++++++++++
 tb/tb_activation_lut_requester.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_lut_requester.sv
`default_nettype none
// ============================================================================
// Module  : activation_lut_requester
// Brief   : Quantizes signed sums to activation-ROM addresses and re-emits
//           the ROM data as a credit-flow-controlled valid/ready stream.
// Revision: 1.0
// ============================================================================
module activation_lut_requester #(
  parameter int ACC_WIDTH  = 16,
  parameter int FRAC_SHIFT = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ACC_WIDTH-1:0]  in_sum,
  input  logic                  in_last,
  output logic [ADDR_WIDTH-1:0] lut_addr,
  input  logic [DATA_WIDTH-1:0] lut_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_sat
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 3);
  localparam int ENT_W = DATA_WIDTH + 2;
  localparam logic signed [ACC_WIDTH-1:0] Q_MAX = ACC_WIDTH'((1 << (ADDR_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] Q_MIN = ~Q_MAX;

  logic signed [ACC_WIDTH-1:0]  q;
  logic [ADDR_WIDTH-1:0]        qs;
  logic [ADDR_WIDTH-1:0]        addr;
  logic                         sat;
  logic                         fire;
  logic                         rst_done;
  logic                         v1, last1, sat1;
  logic                         v2, last2, sat2;
  logic [ENT_W-1:0]             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [CNT_W-1:0]             count;
  logic [OCC_W-1:0]             occupancy;
  logic                         pop;

  // Quantize and saturate
  assign q = $signed(in_sum) >>> FRAC_SHIFT;

  always_comb begin
    qs  = q[ADDR_WIDTH-1:0];
    sat = 1'b0;
    if (q > Q_MAX) begin
      qs  = Q_MAX[ADDR_WIDTH-1:0];
      sat = 1'b1;
    end else if (q < Q_MIN) begin
      qs  = Q_MIN[ADDR_WIDTH-1:0];
      sat = 1'b1;
    end
  end

  // Offset binary: most negative code maps to address 0
  assign addr = {~qs[ADDR_WIDTH-1], qs[ADDR_WIDTH-2:0]};

  // Every accepted sum already owns a FIFO slot, so the pipeline never stalls
  assign occupancy = OCC_W'(count) + OCC_W'(v1) + OCC_W'(v2);
  assign in_ready  = rst_done & (occupancy < OCC_W'(FIFO_DEPTH));
  assign fire      = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done <= 1'b0;
      lut_addr <= '0;
      v1       <= 1'b0;
      last1    <= 1'b0;
      sat1     <= 1'b0;
      v2       <= 1'b0;
      last2    <= 1'b0;
      sat2     <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      v1       <= fire;
      v2       <= v1;
      last2    <= last1;
      sat2     <= sat1;
      if (fire) begin
        lut_addr <= addr;
        last1    <= in_last;
        sat1     <= sat;
      end
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[rd_ptr][ENT_W-1:2];
  assign out_last  = mem[rd_ptr][1];
  assign out_sat   = mem[rd_ptr][0];

  // v2 marks the cycle in which the ROM presents data for the stage-1 address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (v2) begin
        mem[wr_ptr] <= {lut_data, last2, sat2};
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({v2, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_activation_lut_requester.sv
`default_nettype none
// ============================================================================
// Module  : tb_activation_lut_requester
// Brief   : Directed bench for activation_lut_requester with an identity ROM.
// Revision: 1.0
// ============================================================================
module tb_activation_lut_requester;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sum;
  logic        in_last;
  logic [7:0]  lut_addr;
  logic [7:0]  lut_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_sat;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] rx_data [$];
  logic       rx_last [$];
  logic       rx_sat  [$];
  int         rx_cyc  [$];
  int         acc_cyc [$];

  typedef struct {
    logic [15:0] sum;
    logic        last;
    logic [7:0]  exp_data;
    logic        exp_sat;
  } vec_t;

  vec_t vecs [8];

  activation_lut_requester #(
    .ACC_WIDTH (16),
    .FRAC_SHIFT(4),
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sum   (in_sum),
    .in_last  (in_last),
    .lut_addr (lut_addr),
    .lut_data (lut_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_sat  (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Identity ROM with registered output
  always @(posedge clk) lut_data <= lut_addr;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes observed mid-cycle, where inputs and outputs are settled
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      rx_data.push_back(out_data);
      rx_last.push_back(out_last);
      rx_sat.push_back(out_sat);
      rx_cyc.push_back(cyc);
    end
    if (rst_n && in_valid && in_ready) acc_cyc.push_back(cyc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_q();
    rx_data.delete();
    rx_last.delete();
    rx_sat.delete();
    rx_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [15:0] sum, input logic last);
    int b = 0;
    in_valid = 1'b1;
    in_sum   = sum;
    in_last  = last;
    while (!in_ready && b < 50) begin
      step();
      b++;
    end
    if (!in_ready) check("send_ready_timeout", in_ready, 1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_rx(input int n, input string name);
    int b = 0;
    while (rx_data.size() < n && b < 300) begin
      step();
      b++;
    end
    check(name, rx_data.size(), n);
  endtask

  initial begin
    int k, b, stalls, errs, head_changes;
    logic fired, head_seen;
    logic [7:0] head;

    vecs[0] = '{16'h0000, 1'b0, 8'h80, 1'b0};
    vecs[1] = '{16'h0010, 1'b1, 8'h81, 1'b0};
    vecs[2] = '{16'hFFF0, 1'b0, 8'h7F, 1'b0};
    vecs[3] = '{16'hFFFF, 1'b1, 8'h7F, 1'b0};
    vecs[4] = '{16'h7FFF, 1'b0, 8'hFF, 1'b1};
    vecs[5] = '{16'h8000, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{16'h07F0, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{16'h0800, 1'b0, 8'hFF, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_lut_addr", lut_addr, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Quantize / saturation vectors
    for (int i = 0; i < 8; i++) begin
      clear_q();
      out_ready = 1'b1;
      send_one(vecs[i].sum, vecs[i].last);
      check($sformatf("vec%0d_addr", i), lut_addr, vecs[i].exp_data);
      wait_rx(1, $sformatf("vec%0d_count", i));
      if (rx_data.size() > 0) begin
        check($sformatf("vec%0d_data", i), rx_data[0], vecs[i].exp_data);
        check($sformatf("vec%0d_sat", i), rx_sat[0], vecs[i].exp_sat);
        check($sformatf("vec%0d_last", i), rx_last[0], vecs[i].last);
      end
    end
    repeat (3) step();

    // Throughput: 64 back-to-back sums
    clear_q();
    out_ready = 1'b1;
    k = 0; b = 0; stalls = 0;
    while (k < 64 && b < 300) begin
      in_valid = 1'b1;
      in_sum   = 16'(k * 16);
      fired    = in_ready;
      if (k > 0 && !in_ready) stalls++;
      step();
      if (fired) k++;
      b++;
    end
    in_valid = 1'b0;
    check("tp_accepted", k, 64);
    check("tp_stalls", stalls, 0);
    wait_rx(64, "tp_count");
    if (rx_data.size() == 64 && acc_cyc.size() > 0) begin
      check("tp_latency", rx_cyc[0] - acc_cyc[0], 3);
      errs = 0;
      for (int i = 0; i < 64; i++) begin
        if (rx_data[i] !== 8'(8'h80 + i)) errs++;
        if (rx_cyc[i] != rx_cyc[0] + i) errs++;
      end
      check("tp_order_and_rate", errs, 0);
    end
    repeat (3) step();

    // Backpressure: only FIFO_DEPTH sums may be accepted
    clear_q();
    out_ready = 1'b0;
    k = 0; head_seen = 1'b0; head_changes = 0; head = '0;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      in_sum   = 16'(16 * (k + 10));
      fired    = in_ready;
      if (out_valid) begin
        if (!head_seen) begin
          head      = out_data;
          head_seen = 1'b1;
        end else if (out_data !== head) begin
          head_changes++;
        end
      end
      step();
      if (fired) k++;
    end
    check("bp_accepted", acc_cyc.size(), 4);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_head_value", head, 8'h8A);
    check("bp_head_stable", head_changes, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_rx(4, "bp_drain_count");
    errs = 0;
    for (int i = 0; i < rx_data.size(); i++) begin
      if (rx_data[i] !== 8'(8'h8A + i)) errs++;
    end
    check("bp_drain_order", errs, 0);
    repeat (5) step();
    check("bp_no_dup", rx_data.size(), 4);
    check("bp_empty", out_valid, 0);

    // Tag propagation under random backpressure
    clear_q();
    k = 0; b = 0;
    while (k < 8 && b < 300) begin
      in_valid  = 1'b1;
      in_sum    = 16'(16 * k);
      in_last   = (k == 4);
      out_ready = 1'($urandom_range(0, 1));
      fired     = in_ready;
      step();
      if (fired) k++;
      b++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    b = 0;
    while (rx_data.size() < 8 && b < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
      b++;
    end
    out_ready = 1'b1;
    check("tag_count", rx_data.size(), 8);
    for (int i = 0; i < rx_data.size(); i++) begin
      check($sformatf("tag%0d_last", i), rx_last[i], (i == 4));
      check($sformatf("tag%0d_data", i), rx_data[i], 8'(8'h80 + i));
    end
    repeat (3) step();

    // Reset with 2 in flight and 2 buffered
    clear_q();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sum   = 16'(16 * (i + 1));
      step();
    end
    in_valid = 1'b0;
    check("mid_accepted", acc_cyc.size(), 4);
    check("mid_buffered_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_lut_addr", lut_addr, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_q();
    out_ready = 1'b1;
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) errs++;
    end
    check("mid_no_replay", errs, 0);
    send_one(16'h0030, 1'b0);
    wait_rx(1, "mid_new_count");
    if (rx_data.size() > 0) check("mid_new_data", rx_data[0], 8'h83);
    repeat (5) step();
    check("mid_single_result", rx_data.size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
